// File: rtl/instr_fetch_unit_if.sv
// Instruction-side bus of the fetch unit: program ROM read port, control_unit
// handshake/redirect inputs and the assembled-instruction outputs.
interface instr_fetch_unit_if;
  logic        rom_rd_en;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        instr_ready;
  logic        branch_taken;
  logic [9:0]  branch_offset;
  logic        load_pc;
  logic [15:0] load_addr;
  logic [15:0] instruction;
  logic [15:0] instruction_1;
  logic [15:0] instruction_2;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        illegal;
  logic [15:0] pc_out;

  modport master (
    output rom_rd_en, rom_addr, instruction, instruction_1, instruction_2,
           instr_len, instr_pc, instr_valid, illegal, pc_out,
    input  rom_data, instr_ready, branch_taken, branch_offset, load_pc, load_addr
  );

  modport slave (
    input  rom_rd_en, rom_addr, instruction, instruction_1, instruction_2,
           instr_len, instr_pc, instr_valid, illegal, pc_out,
    output rom_data, instr_ready, branch_taken, branch_offset, load_pc, load_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetches 1..3-word instructions from ROM, holds them for control_unit until
// accepted, and owns the PC (sequential advance, branch and forced load).
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RD0, CAP0, RD1, CAP1, RD2, CAP2, HOLD} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] word0_q;
  logic [15:0] word1_q;
  logic [15:0] word2_q;
  logic [15:0] ipc_q;
  logic [1:0]  len_q;
  logic        illegal_q;

  logic [3:0]  op;
  logic [1:0]  as_mode;
  logic        src_ext;
  logic [1:0]  len_d;
  logic        illegal_d;
  logic [15:0] pc_inc_d;
  logic [15:0] pc_br_d;
  logic        rd;

  // Length decode works directly on the ROM word arriving in CAP0.
  always_comb begin
    op        = bus.rom_data[15:12];
    as_mode   = bus.rom_data[5:4];
    src_ext   = 1'b0;
    len_d     = 2'd1;
    illegal_d = 1'b0;
    if (op == 4'h0) begin
      illegal_d = 1'b1;
    end else if (op == 4'h1) begin
      if (as_mode == 2'b01 || (as_mode == 2'b11 && bus.rom_data[3:0] == 4'h0))
        len_d = 2'd2;
    end else if (op >= 4'h4) begin
      src_ext = (as_mode == 2'b01) || (as_mode == 2'b11 && bus.rom_data[11:8] == 4'h0);
      len_d   = 2'd1 + {1'b0, src_ext} + {1'b0, bus.rom_data[7]};
    end
  end

  assign pc_inc_d = pc_q + 16'd2;
  // pc already points past the first word when HOLD is reached.
  assign pc_br_d  = pc_q + {{5{bus.branch_offset[9]}}, bus.branch_offset, 1'b0};

  assign rd                = (state_q == RD0) || (state_q == RD1) || (state_q == RD2);
  assign bus.rom_rd_en     = rd;
  assign bus.rom_addr      = rd ? pc_q : 16'h0000;
  assign bus.instruction   = word0_q;
  assign bus.instruction_1 = word1_q;
  assign bus.instruction_2 = word2_q;
  assign bus.instr_len     = len_q;
  assign bus.instr_pc      = ipc_q;
  assign bus.instr_valid   = (state_q == HOLD);
  assign bus.illegal       = (state_q == HOLD) && illegal_q;
  assign bus.pc_out        = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC & 16'hFFFE;
      word0_q   <= 16'h0000;
      word1_q   <= 16'h0000;
      word2_q   <= 16'h0000;
      ipc_q     <= 16'h0000;
      len_q     <= 2'd0;
      illegal_q <= 1'b0;
    end else if (bus.load_pc) begin
      pc_q    <= bus.load_addr & 16'hFFFE;
      state_q <= RD0;
    end else begin
      case (state_q)
        IDLE: state_q <= RD0;
        RD0:  state_q <= CAP0;
        CAP0: begin
          word0_q   <= bus.rom_data;
          word1_q   <= 16'h0000;
          word2_q   <= 16'h0000;
          ipc_q     <= pc_q;
          len_q     <= len_d;
          illegal_q <= illegal_d;
          pc_q      <= pc_inc_d;
          state_q   <= (len_d > 2'd1) ? RD1 : HOLD;
        end
        RD1:  state_q <= CAP1;
        CAP1: begin
          word1_q <= bus.rom_data;
          pc_q    <= pc_inc_d;
          state_q <= (len_q > 2'd2) ? RD2 : HOLD;
        end
        RD2:  state_q <= CAP2;
        CAP2: begin
          word2_q <= bus.rom_data;
          pc_q    <= pc_inc_d;
          state_q <= HOLD;
        end
        HOLD: begin
          if (bus.instr_ready) begin
            state_q <= RD0;
            if (bus.branch_taken)
              pc_q <= pc_br_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency ROM model.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] mem [0:32767];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial bus.rom_data = 16'h0000;
  always @(posedge clk)
    if (bus.rom_rd_en) bus.rom_data <= mem[bus.rom_addr[15:1]];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
  endtask

  task automatic load(input logic [15:0] addr);
    bus.load_pc   = 1'b1;
    bus.load_addr = addr;
    @(negedge clk);
    bus.load_pc   = 1'b0;
  endtask

  initial begin
    rst               = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 10'h000;
    bus.load_pc       = 1'b0;
    bus.load_addr     = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h4405;
    mem[16'h0001] = 16'h4405;
    mem[16'h0080] = 16'h4596;
    mem[16'h0081] = 16'h0010;
    mem[16'h0082] = 16'h0020;
    mem[16'h0083] = 16'h4034;
    mem[16'h0084] = 16'h1234;
    mem[16'h0085] = 16'h1015;
    mem[16'h0086] = 16'h0008;
    mem[16'h0087] = 16'h0000;
    mem[16'h0008] = 16'h3C02;
    mem[16'h0009] = 16'h4405;
    mem[16'h000B] = 16'h4405;
    mem[16'h0101] = 16'h4405;
    mem[16'h7FFF] = 16'h4405;

    // Reset state
    @(negedge clk);
    chk("rst_rd_en", {15'd0, bus.rom_rd_en}, 16'h0000);
    chk("rst_addr", bus.rom_addr, 16'h0000);
    chk("rst_valid", {15'd0, bus.instr_valid}, 16'h0000);
    chk("rst_instr", bus.instruction, 16'h0000);
    chk("rst_pc", bus.pc_out, 16'h0000);
    chk("rst_len", {14'd0, bus.instr_len}, 16'h0000);
    rst = 1'b1;

    // 1-word instruction at 0x0000
    @(negedge clk);
    chk("rd0_en", {15'd0, bus.rom_rd_en}, 16'h0001);
    chk("rd0_addr", bus.rom_addr, 16'h0000);
    @(negedge clk);
    chk("cap0_valid", {15'd0, bus.instr_valid}, 16'h0000);
    @(negedge clk);
    chk("l1_valid", {15'd0, bus.instr_valid}, 16'h0001);
    chk("l1_instr", bus.instruction, 16'h4405);
    chk("l1_len", {14'd0, bus.instr_len}, 16'h0001);
    chk("l1_ipc", bus.instr_pc, 16'h0000);
    chk("l1_pc", bus.pc_out, 16'h0002);
    chk("l1_ext1", bus.instruction_1, 16'h0000);
    chk("l1_illegal", {15'd0, bus.illegal}, 16'h0000);
    handshake();
    chk("l1_next_addr", bus.rom_addr, 16'h0002);
    chk("l1_nb2b", {15'd0, bus.instr_valid}, 16'h0000);

    // 3-word instruction at 0x0100
    load(16'h0100);
    chk("l3_addr0", bus.rom_addr, 16'h0100);
    repeat (2) @(negedge clk);
    chk("l3_addr1", bus.rom_addr, 16'h0102);
    repeat (2) @(negedge clk);
    chk("l3_addr2", bus.rom_addr, 16'h0104);
    @(negedge clk);
    chk("l3_t5_valid", {15'd0, bus.instr_valid}, 16'h0000);
    @(negedge clk);
    chk("l3_valid", {15'd0, bus.instr_valid}, 16'h0001);
    chk("l3_len", {14'd0, bus.instr_len}, 16'h0003);
    chk("l3_instr", bus.instruction, 16'h4596);
    chk("l3_ext1", bus.instruction_1, 16'h0010);
    chk("l3_ext2", bus.instruction_2, 16'h0020);
    chk("l3_pc", bus.pc_out, 16'h0106);
    chk("l3_ipc", bus.instr_pc, 16'h0100);
    repeat (5) @(negedge clk);
    chk("hold_valid", {15'd0, bus.instr_valid}, 16'h0001);
    chk("hold_instr", bus.instruction, 16'h4596);
    chk("hold_ext2", bus.instruction_2, 16'h0020);
    chk("hold_pc", bus.pc_out, 16'h0106);
    chk("hold_rd_en", {15'd0, bus.rom_rd_en}, 16'h0000);
    handshake();
    chk("imm_addr0", bus.rom_addr, 16'h0106);
    chk("l3_nb2b", {15'd0, bus.instr_valid}, 16'h0000);

    // Immediate source: 2 words
    repeat (4) @(negedge clk);
    chk("imm_valid", {15'd0, bus.instr_valid}, 16'h0001);
    chk("imm_len", {14'd0, bus.instr_len}, 16'h0002);
    chk("imm_instr", bus.instruction, 16'h4034);
    chk("imm_ext1", bus.instruction_1, 16'h1234);
    chk("imm_ext2", bus.instruction_2, 16'h0000);
    chk("imm_pc", bus.pc_out, 16'h010A);
    handshake();
    chk("rrc_addr0", bus.rom_addr, 16'h010A);

    // Single-operand indexed: 2 words
    repeat (4) @(negedge clk);
    chk("rrc_len", {14'd0, bus.instr_len}, 16'h0002);
    chk("rrc_instr", bus.instruction, 16'h1015);
    chk("rrc_ext1", bus.instruction_1, 16'h0008);
    handshake();
    chk("ill_addr0", bus.rom_addr, 16'h010E);

    // Illegal opcode 0
    repeat (2) @(negedge clk);
    chk("ill_valid", {15'd0, bus.instr_valid}, 16'h0001);
    chk("ill_flag", {15'd0, bus.illegal}, 16'h0001);
    chk("ill_len", {14'd0, bus.instr_len}, 16'h0001);
    handshake();

    // Forward branch +2 words
    load(16'h0010);
    chk("br_addr0", bus.rom_addr, 16'h0010);
    repeat (2) @(negedge clk);
    chk("br_instr", bus.instruction, 16'h3C02);
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 10'h002;
    @(negedge clk);
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    chk("br_fwd_addr", bus.rom_addr, 16'h0016);

    // Branch to self (offset -1)
    mem[16'h0008] = 16'h3FFF;
    load(16'h0010);
    chk("br_self_addr0", bus.rom_addr, 16'h0010);
    repeat (2) @(negedge clk);
    chk("br_self_instr", bus.instruction, 16'h3FFF);
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 10'h3FF;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    chk("br_self_addr", bus.rom_addr, 16'h0010);

    // branch_taken outside handshake is ignored; then not-taken handshake
    repeat (2) @(negedge clk);
    chk("br_ign_valid", {15'd0, bus.instr_valid}, 16'h0001);
    chk("br_ign_pc", bus.pc_out, 16'h0012);
    bus.branch_taken = 1'b0;
    handshake();
    chk("br_nt_addr", bus.rom_addr, 16'h0012);

    // PC wrap from 0xFFFE
    load(16'hFFFE);
    chk("wrap_addr0", bus.rom_addr, 16'hFFFE);
    repeat (2) @(negedge clk);
    chk("wrap_ipc", bus.instr_pc, 16'hFFFE);
    chk("wrap_pc", bus.pc_out, 16'h0000);
    handshake();
    chk("wrap_next_addr", bus.rom_addr, 16'h0000);

    // load_pc during CAP1 discards the partial fetch
    load(16'h0100);
    chk("ld_addr0", bus.rom_addr, 16'h0100);
    repeat (3) @(negedge clk);
    load(16'h0203);
    chk("ld_addr", bus.rom_addr, 16'h0202);
    chk("ld_valid", {15'd0, bus.instr_valid}, 16'h0000);
    chk("ld_pc", bus.pc_out, 16'h0202);
    @(negedge clk);
    chk("ld_cap_valid", {15'd0, bus.instr_valid}, 16'h0000);
    @(negedge clk);
    chk("ld_instr", bus.instruction, 16'h4405);
    chk("ld_ipc", bus.instr_pc, 16'h0202);
    chk("ld_ext1", bus.instruction_1, 16'h0000);

    // load_pc overrides a held instruction, then async reset during RD2
    load(16'h0100);
    chk("ldh_valid", {15'd0, bus.instr_valid}, 16'h0000);
    chk("ldh_addr", bus.rom_addr, 16'h0100);
    repeat (4) @(negedge clk);
    chk("rd2_addr", bus.rom_addr, 16'h0104);
    #2 rst = 1'b0;
    #1;
    chk("arst_rd_en", {15'd0, bus.rom_rd_en}, 16'h0000);
    chk("arst_addr", bus.rom_addr, 16'h0000);
    chk("arst_instr", bus.instruction, 16'h0000);
    chk("arst_pc", bus.pc_out, 16'h0000);
    chk("arst_len", {14'd0, bus.instr_len}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("refetch_en", {15'd0, bus.rom_rd_en}, 16'h0001);
    chk("refetch_addr", bus.rom_addr, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
